// File: rtl/fsm_trace_pkg.sv
// Shared definitions for the FSM trace checker: state codes, record layout and
// the reference next-state / legality functions of the five-state sequence FSM.
package fsm_trace_pkg;

    localparam logic [2:0] Q0 = 3'd2;
    localparam logic [2:0] Q1 = 3'd6;
    localparam logic [2:0] Q2 = 3'd4;
    localparam logic [2:0] Q3 = 3'd7;
    localparam logic [2:0] Q4 = 3'd1;

    localparam int REC_W = 5;

    typedef struct packed {
        logic       illegal;
        logic       mismatch;
        logic [2:0] code;
    } trace_rec_t;

    function automatic logic code_legal(input logic [2:0] code);
        return (code == Q0) || (code == Q1) || (code == Q2) ||
               (code == Q3) || (code == Q4);
    endfunction

    // Only meaningful for legal codes; illegal codes are never checked against it.
    function automatic logic [2:0] next_code(input logic [2:0] code, input logic a);
        logic [2:0] nxt;
        nxt = Q0;
        case (code)
            Q0:      nxt = Q2;
            Q1:      nxt = Q3;
            Q2:      nxt = a ? Q1 : Q4;
            Q3:      nxt = a ? Q0 : Q2;
            Q4:      nxt = Q1;
            default: nxt = Q0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/fsm_trace_checker_if.sv
// Record stream from the trace checker to its host: valid/ready handshake
// carrying one trace_rec_t per transfer.
interface fsm_trace_checker_if;
    import fsm_trace_pkg::*;

    logic       out_valid;
    logic       out_ready;
    trace_rec_t out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/fsm_trace_fifo.sv
// Synchronous first-word fall-through FIFO; an extra pointer bit separates
// full from empty. A push into a full FIFO is accepted only alongside a pop.
module fsm_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         accepted,
    output logic         valid,
    output logic [W-1:0] head_data
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr_reg;
    logic [AW:0]  rd_ptr_reg;
    logic         empty;
    logic         full;
    logic         pop_ok;

    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop_ok   = pop & ~empty;
    assign accepted = push & (~full | pop_ok);
    assign valid    = ~empty;
    // Head forced to zero while empty so the stale slot never leaks out.
    assign head_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (accepted) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (pop_ok)   rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accepted) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fsm_trace_checker.sv
// Checks the sequence FSM's state code trace for illegal codes and bad transitions.
// FSM_TRACE_CHECKER_FIFO_EN selects a record FIFO; otherwise a single pulsed record register.
module fsm_trace_checker
    import fsm_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      a,
    input  logic [2:0]                saida,
    input  logic                      in_en,
    fsm_trace_checker_if.master       rec,
    output logic                      err_flag,
    output logic [CNT_W-1:0]          err_cnt,
    output logic [CNT_W-1:0]          ovf_cnt
);
    logic [2:0]       prev_code_reg;
    logic             prev_a_reg;
    logic             prev_valid_reg;
    logic             err_flag_reg;
    logic [CNT_W-1:0] err_cnt_reg;
    trace_rec_t       rec_now;
    logic             sample_err;

    always_comb begin
        rec_now.code     = saida;
        rec_now.illegal  = ~code_legal(saida);
        rec_now.mismatch = prev_valid_reg && code_legal(prev_code_reg) &&
                           (saida != next_code(prev_code_reg, prev_a_reg));
        sample_err       = in_en & (rec_now.illegal | rec_now.mismatch);
    end

    // A disabled cycle breaks the history: the next sample is legality-only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_code_reg  <= '0;
            prev_a_reg     <= 1'b0;
            prev_valid_reg <= 1'b0;
        end else if (in_en) begin
            prev_code_reg  <= saida;
            prev_a_reg     <= a;
            prev_valid_reg <= 1'b1;
        end else begin
            prev_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_flag_reg <= 1'b0;
            err_cnt_reg  <= '0;
        end else if (sample_err) begin
            err_flag_reg <= 1'b1;
            if (err_cnt_reg != '1) err_cnt_reg <= err_cnt_reg + CNT_W'(1);
        end
    end

    assign err_flag = err_flag_reg;
    assign err_cnt  = err_cnt_reg;

`ifdef FSM_TRACE_CHECKER_FIFO_EN
    logic             fifo_accepted;
    logic             fifo_valid;
    logic [REC_W-1:0] fifo_head;
    logic [CNT_W-1:0] ovf_cnt_reg;

    fsm_trace_fifo #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_en),
        .push_data (rec_now),
        .pop       (rec.out_ready),
        .accepted  (fifo_accepted),
        .valid     (fifo_valid),
        .head_data (fifo_head)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_cnt_reg <= '0;
        end else if (in_en && !fifo_accepted && ovf_cnt_reg != '1) begin
            ovf_cnt_reg <= ovf_cnt_reg + CNT_W'(1);
        end
    end

    assign rec.out_valid = fifo_valid;
    assign rec.out_data  = fifo_head;
    assign ovf_cnt       = ovf_cnt_reg;
`else
    logic                   out_valid_reg;
    trace_rec_t             out_data_reg;
    logic                   unused_ready;
    logic [$clog2(DEPTH):0] unused_depth;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            out_valid_reg <= in_en;
            if (in_en) out_data_reg <= rec_now;
        end
    end

    assign rec.out_valid = out_valid_reg;
    assign rec.out_data  = out_data_reg;
    assign ovf_cnt       = '0;
    assign unused_ready  = rec.out_ready;
    assign unused_depth  = '0;
`endif

endmodule

// File: tb/tb_fsm_trace_checker.sv
// Randomised and directed bench for fsm_trace_checker against a queue-based model;
// follows the build's FSM_TRACE_CHECKER_FIFO_EN setting.
module tb_fsm_trace_checker;
    localparam int DEPTH = 8;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             a = 1'b0;
    logic             in_en = 1'b0;
    logic [2:0]       saida = 3'd0;
    logic             err_flag;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] ovf_cnt;

    fsm_trace_checker_if rec_if();

    fsm_trace_checker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .saida    (saida),
        .in_en    (in_en),
        .rec      (rec_if),
        .err_flag (err_flag),
        .err_cnt  (err_cnt),
        .ovf_cnt  (ovf_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: successor tables (0 marks an illegal code), record queue / last record.
    logic [2:0] succ0 [8];
    logic [2:0] succ1 [8];
    logic [4:0] q [$];
    logic [4:0] m_last;
    bit         m_valid;
    bit         m_have_prev;
    logic [2:0] m_pc;
    logic       m_pa;
    bit         m_flag;
    int         m_err;
    int         m_ovf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_last = '0;
        m_valid = 0;
        m_have_prev = 0;
        m_pc = '0;
        m_pa = 1'b0;
        m_flag = 0;
        m_err = 0;
        m_ovf = 0;
    endtask

    task automatic model_edge();
        bit         ill;
        bit         mis;
        logic [2:0] want;
        logic [4:0] r;
        ill  = (succ0[saida] == 3'd0);
        want = m_pa ? succ1[m_pc] : succ0[m_pc];
        mis  = m_have_prev && (succ0[m_pc] != 3'd0) && (saida != want);
        r    = {ill, mis, saida};
`ifdef FSM_TRACE_CHECKER_FIFO_EN
        begin
            int sz;
            bit pop;
            sz  = q.size();
            pop = (sz > 0) && rec_if.out_ready;
            if (pop) void'(q.pop_front());
            if (in_en) begin
                if (sz < DEPTH || pop) q.push_back(r);
                else if (m_ovf < CMAX) m_ovf++;
            end
        end
`else
        m_valid = in_en;
        if (in_en) m_last = r;
`endif
        if (in_en && (ill || mis)) begin
            m_flag = 1;
            if (m_err < CMAX) m_err++;
        end
        if (in_en) begin
            m_have_prev = 1;
            m_pc = saida;
            m_pa = a;
        end else begin
            m_have_prev = 0;
        end
    endtask

    task automatic check_outputs();
        chk("err_flag", err_flag, m_flag);
        chk("err_cnt", err_cnt, m_err);
        chk("ovf_cnt", ovf_cnt, m_ovf);
`ifdef FSM_TRACE_CHECKER_FIFO_EN
        chk("out_valid", rec_if.out_valid, q.size() > 0);
        if (q.size() > 0) chk("out_data", rec_if.out_data, q[0]);
`else
        chk("out_valid", rec_if.out_valid, m_valid);
        chk("out_data", rec_if.out_data, m_last);
`endif
    endtask

    task automatic cyc(input logic [2:0] c, input logic av, input logic en, input logic rdy);
        saida = c;
        a = av;
        in_en = en;
        rec_if.out_ready = rdy;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        $display("t=%0t en=%0b a=%0b saida=%0d rdy=%0b -> valid=%0b data=%05b flag=%0b err=%0d ovf=%0d",
                 $time, en, av, c, rdy, rec_if.out_valid, rec_if.out_data, err_flag, err_cnt, ovf_cnt);
    endtask

    // Called one time unit after a rising edge; reset must act without a clock.
    task automatic do_reset();
        in_en = 1'b0;
        rec_if.out_ready = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_valid", rec_if.out_valid, 1'b0);
        chk("rst_data", rec_if.out_data, 5'd0);
        chk("rst_flag", err_flag, 1'b0);
        chk("rst_err", err_cnt, 0);
        chk("rst_ovf", ovf_cnt, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [2:0] cur;
        logic       cur_a;
        logic [2:0] last;
        logic       last_a;
        bit         last_en;

        for (int i = 0; i < 8; i++) begin
            succ0[i] = 3'd0;
            succ1[i] = 3'd0;
        end
        succ0[2] = 3'd4; succ1[2] = 3'd4;
        succ0[6] = 3'd7; succ1[6] = 3'd7;
        succ0[4] = 3'd1; succ1[4] = 3'd6;
        succ0[7] = 3'd4; succ1[7] = 3'd2;
        succ0[1] = 3'd6; succ1[1] = 3'd6;

        model_reset();
        rec_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_valid", rec_if.out_valid, 1'b0);
        chk("init_data", rec_if.out_data, 5'd0);
        chk("init_err", err_cnt, 0);
        reset = 1'b1;

        // True FSM trace
        cyc(3'd2, 0, 1, 1);
        cyc(3'd4, 0, 1, 1);
        cyc(3'd1, 0, 1, 1);
        cyc(3'd6, 0, 1, 1);
        cyc(3'd7, 1, 1, 1);
        cyc(3'd2, 0, 1, 1);
        chk("trace_err", err_cnt, 0);
        chk("trace_flag", err_flag, 1'b0);

        // Wrong transition: 4 with a=1 must go to 6, not 1
        do_reset();
        cyc(3'd4, 1, 1, 1);
        cyc(3'd1, 0, 1, 1);
        chk("wrong_rec", rec_if.out_data, 5'b01001);
        chk("wrong_err", err_cnt, 1);
        chk("wrong_flag", err_flag, 1'b1);

        // Illegal code, then no transition check
        do_reset();
        cyc(3'd5, 0, 1, 1);
        chk("illegal_rec", rec_if.out_data, 5'b10101);
        cyc(3'd2, 0, 1, 1);
        chk("after_illegal_rec", rec_if.out_data, 5'b00010);
        chk("after_illegal_err", err_cnt, 1);

        // Enable gap breaks history
        do_reset();
        cyc(3'd6, 0, 1, 1);
        cyc(3'd0, 0, 0, 1);
        cyc(3'd4, 0, 1, 1);
        chk("gap_rec", rec_if.out_data, 5'b00100);
        chk("gap_err", err_cnt, 0);

        // Fill past full with no pops, then drain
        do_reset();
        cur = 3'd2;
        for (int i = 0; i < DEPTH + 3; i++) begin
            cur_a = 1'($urandom_range(0, 1));
            cyc(cur, cur_a, 1, 0);
            cur = cur_a ? succ1[cur] : succ0[cur];
        end
`ifdef FSM_TRACE_CHECKER_FIFO_EN
        chk("full_valid", rec_if.out_valid, 1'b1);
        chk("full_ovf", ovf_cnt, 3);
        chk("full_head", rec_if.out_data, 5'b00010);
`endif
        for (int i = 0; i < DEPTH; i++) cyc(3'd0, 0, 0, 1);
        chk("drained_valid", rec_if.out_valid, 1'b0);

        // Reset mid-stream with 5 queued records and a nonzero error count
        do_reset();
        cyc(3'd2, 0, 1, 0);
        cyc(3'd4, 0, 1, 0);
        cyc(3'd3, 0, 1, 0);
        cyc(3'd2, 0, 1, 0);
        cyc(3'd4, 1, 1, 0);
        do_reset();
        cyc(3'd1, 0, 1, 0);
        chk("post_rst_rec", rec_if.out_data, 5'b00001);
        chk("post_rst_err", err_cnt, 0);

        // Counter saturation
        do_reset();
        for (int i = 0; i < CMAX + 20; i++) cyc(3'd0, 0, 1, 0);
        chk("sat_err", err_cnt, CMAX);
        for (int i = 0; i < DEPTH + 1; i++) cyc(3'd0, 0, 0, 1);

        // Random mostly-legal traces with gaps and back-pressure
        do_reset();
        last = 3'd2;
        last_a = 1'b0;
        last_en = 0;
        for (int i = 0; i < 600; i++) begin
            logic [2:0] c;
            logic       av;
            bit         en;
            en = ($urandom_range(0, 9) != 0);
            av = 1'($urandom_range(0, 1));
            if (last_en && succ0[last] != 3'd0 && $urandom_range(0, 9) < 8)
                c = last_a ? succ1[last] : succ0[last];
            else
                c = 3'($urandom_range(0, 7));
            cyc(c, av, en, ($urandom_range(0, 3) != 0));
            last_en = en;
            if (en) begin
                last = c;
                last_a = av;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fsm_trace_checker.md
# fsm_trace_checker

Downstream consumer of the 3-bit state code (`saida`) produced by the five-state sequence FSM, together with the input bit `a` that drives it. Each enabled cycle it checks code legality and transition legality against the FSM's next-state table, and keeps a saturating error count and a sticky error flag. It also buffers one check record per sample in a small FIFO that a host drains through a valid/ready interface.

## Interface
- `DEPTH`, 8: FIFO depth in records; must be a power of two, ≥ 2.
- `CNT_W`, 8: width of the error and overflow counters.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `a` in 1: FSM input bit for the current cycle.
- `saida` in 3: FSM state code for the current cycle.
- `in_en` in 1: sample enable; when 1, (`saida`, `a`) are checked and recorded at this edge.
- `out_valid` out 1: a record is available on `out_data`.
- `out_ready` in 1: consumer accepts the record; pop on `out_valid & out_ready`.
- `out_data` out 5: record {illegal, mismatch, code[2:0]}.
- `err_flag` out 1: sticky; set on any illegal or mismatch sample.
- `err_cnt` out CNT_W: saturating count of erroneous samples.
- `ovf_cnt` out CNT_W: saturating count of records dropped on full FIFO.

## Operation
- Legal codes: Q0=2, Q1=6, Q2=4, Q3=7, Q4=1. Every other value (0, 3, 5) is illegal.
- Expected next code from the previous sample (code, a):
  - Q0 → Q2, for either a.
  - Q1 → Q3.
  - Q2 → Q1 if a=1, Q4 if a=0.
  - Q3 → Q0 if a=1, Q2 if a=0.
  - Q4 → Q1.
- Internal registers: `prev_code`, `prev_a`, `prev_valid`.
- On an edge with `in_en=1`:
  - illegal = `saida` not in the legal set.
  - mismatch = `prev_valid` & prev_code legal & `saida` ≠ expected(prev_code, prev_a).
  - Then `prev_code`/`prev_a` ← inputs; `prev_valid` ← 1.
- An edge with `in_en=0` clears `prev_valid`. The next sample after a gap is checked for legality only.
- An illegal previous code yields no mismatch check on the following sample; only its own illegal bit is set.
- If illegal | mismatch:
  - `err_flag` ← 1; it is cleared only by reset.
  - `err_cnt` increments, saturating at 2^CNT_W−1.
- Each sample pushes one record.
- FIFO full and no pop at the same edge: the record is dropped and `ovf_cnt` saturating-increments. The error counters still update.
- Full with simultaneous pop: the push is accepted and the occupancy is unchanged.
- Empty with simultaneous push: no pop occurs. The record becomes visible on the next cycle.
- Pointers wrap modulo DEPTH. Full and empty are distinguished with an extra pointer bit.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `err_flag`=0, `err_cnt`=0, `ovf_cnt`=0.
  - `prev_valid`=0, `prev_code`=0, `prev_a`=0; FIFO empty.
- Reset asserted mid-operation discards all FIFO contents and history immediately. There is no partial record.
- Latency: a sample taken at edge N gives `err_flag`/`err_cnt` updated after edge N. With the FIFO previously empty, `out_valid`=1 and `out_data` = that record after edge N (first-word fall-through).
- `out_data` is held stable while `out_valid=1` and `out_ready=0`.
- Throughput: one sample and one pop per cycle sustained.

## Configuration
- `FSM_TRACE_CHECKER_FIFO_EN` defined: FIFO of DEPTH records as above.
- Undefined: no FIFO and `ovf_cnt` is tied to 0. `out_data` is a single register loaded on every sample. `out_valid` is a one-cycle pulse after each sampling edge, and `out_ready` is ignored. Checking and counters are unchanged.

## Structure
- Package `fsm_trace_pkg` holds:
  - localparams Q0..Q4 with the codes above;
  - the 5-bit record typedef;
  - a function `next_code(code, a)` returning the expected code, plus a legality function.
- One sub-module, `fsm_trace_fifo`: parameterised synchronous FIFO with first-word fall-through. It is instantiated only under `FSM_TRACE_CHECKER_FIFO_EN`.

## Test plan
- Reset, then `in_en=1` with the true FSM sequence 2,4,1,6,7,2 (a=0,0,0,0,1): records all {0,0,code}, `err_cnt`=0, `err_flag`=0.
- Legal codes with a wrong transition, 4 with a=1 followed by 1: that record is {0,1,1}, `err_cnt`=1, `err_flag`=1.
- Illegal code 5, then 2: records {1,0,5} then {0,0,2} (no check after an illegal code); `err_cnt`=1.
- `in_en` gap: 6, gap, 4 → record {0,0,4}, no mismatch.
- With `out_ready=0`, push DEPTH+3 samples: `out_valid`=1, `ovf_cnt`=3, first record still on `out_data`. Then `out_ready=1` for DEPTH cycles drains in order to `out_valid`=0.
- Assert `reset` mid-stream with the FIFO at 5 entries: `out_valid`=0 and all counters/flags 0 immediately. The first post-reset sample is legality-only.
